chunked_borrow_subtractor: RTL and testbench
============================================

Name: chunked_borrow_subtractor

Overview:
- Multi-cycle subtractor: computes diff = a - b by rippling a borrow across DATA_WIDTH in CHUNK_WIDTH-bit slices, one slice per clock.
- Inverse datapath companion to the team's ripple-carry adder; trades latency for a short critical path.
- Valid/ready on input and output; sits between operand-issue logic and result consumers in the arithmetic unit.

Parameters:
- DATA_WIDTH, 8, operand/result width; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 2, bits processed per cycle; 1 <= CHUNK_WIDTH <= DATA_WIDTH.

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  DATA_WIDTH  minuend, unsigned
- b  input  DATA_WIDTH  subtrahend, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  DATA_WIDTH  (a - b) mod 2^DATA_WIDTH
- borrow_out  output  1  1 when a < b (unsigned)

Behaviour:
- Interface contract: one clock (clk); reset is asynchronous and active-low (resetn).
- NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH. chunk_idx is $clog2(NUM_CHUNKS)+1 bits wide.
- Reset (async, resetn=0):
  - state=IDLE; in_ready=1; out_valid=0; diff=0; borrow_out=0.
  - Internal borrow, chunk_idx and operand registers cleared.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, latch a and b, clear borrow and chunk_idx, go to BUSY.
  - BUSY: in_ready=0. Each cycle, slice i = chunk_idx computes a_i - b_i - borrow. It writes diff[i*CW +: CW], updates borrow, and increments chunk_idx. On the last slice (chunk_idx == NUM_CHUNKS-1), borrow_out takes the final borrow and the FSM goes to DONE.
  - DONE: out_valid=1; diff and borrow_out held stable. On out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency:
  - Accept edge at cycle T; out_valid=1 from the edge at T+NUM_CHUNKS.
  - Throughput is one operation per NUM_CHUNKS+2 cycles minimum. No accept occurs in DONE, even when out_ready=1.
- Stability:
  - Operand ports are ignored outside the accept edge; changing a or b during BUSY has no effect.
  - diff and borrow_out change only during BUSY. They stay stable in DONE and in IDLE until the next operation overwrites the slices.
- Backpressure: out_ready low in DONE holds the result indefinitely; in_ready stays 0.
- Boundaries:
  - a == b gives diff=0, borrow_out=0.
  - a=0, b=all-ones gives diff=1, borrow_out=1.
  - CHUNK_WIDTH == DATA_WIDTH gives a single BUSY cycle (latency 1).
- Reset mid-operation: resetn low in BUSY or DONE aborts immediately. The partial result is discarded, outputs return to reset values, and there is no spurious out_valid after release.
- out_ready while not in DONE is ignored.

Optional Feature:
- Macro: CHUNKED_SUB_SIGNED_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - Set in the final BUSY cycle to (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), i.e. two's-complement signed overflow.
  - Held with diff.
- Undefined: port absent; no extra logic.

Decomposition:
- Package chunked_sub_pkg: state enum typedef (IDLE, BUSY, DONE) and a function computing NUM_CHUNKS.
- Sub-module sub_chunk: purely combinational CHUNK_WIDTH-bit borrow-ripple slice.
  - Inputs: a_s, b_s, bin. Outputs: d_s, bout.
  - Built from per-bit full-subtractor equations.
- The top level holds the FSM, registers and the slice mux.

Test Plan:
- DATA_WIDTH=8, CHUNK_WIDTH=2; a=0x10, b=0x01 -> diff=0x0F, borrow_out=0, out_valid exactly 4 cycles after accept.
- a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. Then a=0xAB, b=0xAB -> diff=0x00, borrow_out=0.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, diff and borrow_out stable; in_ready=0; in_valid pulses ignored.
- Drop resetn 2 cycles into BUSY, then release and drive a=0x05, b=0x03 -> out_valid=0 until the new result diff=0x02 appears 4 cycles after its accept.
- CHUNK_WIDTH=8; a=0x80, b=0x01 -> diff=0x7F after 1 cycle. With CHUNKED_SUB_SIGNED_OVF_EN defined, ovf=1; with a=0x05, b=0x03, ovf=0.
- Random sweep of 1000 operand pairs with random out_ready -> {borrow_out, diff} == ({1'b0,a} - {1'b0,b}) masked to 9 bits.

Source files
------------

// File: rtl/chunked_borrow_subtractor_pkg.sv
// ============================================================================
// Module      : chunked_sub_pkg
// Description : Shared state encoding and sizing helper for the chunked
//               borrow-ripple subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chunked_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int data_width, input int chunk_width);
        return data_width / chunk_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chunked_borrow_subtractor_if.sv
// ============================================================================
// Module      : chunked_borrow_subtractor_if
// Description : Operand/result handshake bundle for the chunked subtractor.
//               CHUNKED_SUB_SIGNED_OVF_EN adds the signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chunked_borrow_subtractor_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] diff;
    logic                  borrow_out;
`ifdef CHUNKED_SUB_SIGNED_OVF_EN
    logic                  ovf;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out, ovf
    );
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out
    );
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out
    );
`endif
endinterface

`default_nettype wire

// File: rtl/chunked_borrow_subtractor_sub_chunk.sv
// ============================================================================
// Module      : sub_chunk
// Description : Combinational CHUNK_WIDTH-bit borrow-ripple subtractor slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_chunk #(
    parameter int CHUNK_WIDTH = 2
) (
    input  wire logic [CHUNK_WIDTH-1:0] a_s,
    input  wire logic [CHUNK_WIDTH-1:0] b_s,
    input  wire logic                   bin,
    output logic      [CHUNK_WIDTH-1:0] d_s,
    output logic                        bout
);

    logic [CHUNK_WIDTH:0] w_borrow;

    assign w_borrow[0] = bin;

    generate
        for (genvar i = 0; i < CHUNK_WIDTH; i++) begin : g_bit
            assign d_s[i]         = a_s[i] ^ b_s[i] ^ w_borrow[i];
            assign w_borrow[i+1]  = (~a_s[i] & b_s[i]) | (~(a_s[i] ^ b_s[i]) & w_borrow[i]);
        end
    endgenerate

    assign bout = w_borrow[CHUNK_WIDTH];

endmodule

`default_nettype wire

// File: rtl/chunked_borrow_subtractor.sv
// ============================================================================
// Module      : chunked_borrow_subtractor
// Description : Multi-cycle a - b, one CHUNK_WIDTH slice per clock.
//               CHUNKED_SUB_SIGNED_OVF_EN adds a registered signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_borrow_subtractor
    import chunked_sub_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CHUNK_WIDTH = 2
) (
    input  wire logic                  clk,
    input  wire logic                  resetn,
    chunked_borrow_subtractor_if.slave bus
);

    localparam int NUM_CHUNKS = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
    localparam int IDX_W      = $clog2(NUM_CHUNKS) + 1;
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [DATA_WIDTH-1:0] SLICE_MASK = DATA_WIDTH'({CHUNK_WIDTH{1'b1}});

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic                    borrow_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   diff_q;
    logic [DATA_WIDTH-1:0]   diff_d;
    logic                    borrow_out_q;
    logic                    in_ready_q;
    logic                    out_valid_q;

    logic [31:0]             w_shamt;
    logic [CHUNK_WIDTH-1:0]  w_a_sl;
    logic [CHUNK_WIDTH-1:0]  w_b_sl;
    logic [CHUNK_WIDTH-1:0]  w_d_sl;
    logic                    w_bout;

    // Slice mux: the active chunk is shifted down to bit 0 of each operand.
    assign w_shamt = 32'(idx_q) * 32'(CHUNK_WIDTH);
    assign w_a_sl  = CHUNK_WIDTH'(a_q >> w_shamt);
    assign w_b_sl  = CHUNK_WIDTH'(b_q >> w_shamt);

    sub_chunk #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_slice (
        .a_s  (w_a_sl),
        .b_s  (w_b_sl),
        .bin  (borrow_q),
        .d_s  (w_d_sl),
        .bout (w_bout)
    );

    assign diff_d = (diff_q & ~(SLICE_MASK << w_shamt)) | (DATA_WIDTH'(w_d_sl) << w_shamt);

`ifdef CHUNKED_SUB_SIGNED_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Final slice carries the result MSB, so overflow is resolved on the last BUSY cycle.
    assign ovf_d = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &
                   (w_d_sl[CHUNK_WIDTH-1] != a_q[DATA_WIDTH-1]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
        end else if (state_q == BUSY && idx_q == LAST_IDX) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            idx_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        borrow_q   <= 1'b0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q   <= diff_d;
                    borrow_q <= w_bout;
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        borrow_out_q <= w_bout;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;

endmodule

`default_nettype wire

// File: tb/tb_chunked_borrow_subtractor.sv
// ============================================================================
// Module      : tb_chunked_borrow_subtractor
// Description : Self-checking bench for a 2-bit-chunk and a single-chunk
//               8-bit subtractor; CHUNKED_SUB_SIGNED_OVF_EN enables ovf checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunked_borrow_subtractor;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_fail;

    chunked_borrow_subtractor_if #(.DATA_WIDTH(8)) ifn ();
    chunked_borrow_subtractor_if #(.DATA_WIDTH(8)) ifw ();

    chunked_borrow_subtractor #(.DATA_WIDTH(8), .CHUNK_WIDTH(2)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifn.slave)
    );

    chunked_borrow_subtractor #(.DATA_WIDTH(8), .CHUNK_WIDTH(8)) u_dut_w (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bor;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ovf, in_ready, out_valid, borrow_out, diff}
    function automatic logic [11:0] st(input bit wide);
        logic ov;
        ov = 1'b0;
`ifdef CHUNKED_SUB_SIGNED_OVF_EN
        ov = wide ? ifw.ovf : ifn.ovf;
`endif
        if (wide)
            return {ov, ifw.in_ready, ifw.out_valid, ifw.borrow_out, ifw.diff};
        return {ov, ifn.in_ready, ifn.out_valid, ifn.borrow_out, ifn.diff};
    endfunction

    task automatic drv(input bit wide, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic rdy);
        if (wide) begin
            ifw.in_valid = v; ifw.a = a; ifw.b = b; ifw.out_ready = rdy;
        end else begin
            ifn.in_valid = v; ifn.a = a; ifn.b = b; ifn.out_ready = rdy;
        end
    endtask

    task automatic run_op(input bit wide, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_diff, input logic exp_bor,
                          input bit chk_ovf, input logic exp_ovf,
                          input int exp_lat, input int hold, input bit rnd_rdy,
                          input string tag);
        logic [11:0] s;
        logic [11:0] s0;
        int lat;
        s = st(wide);
        check({tag, ".in_ready_idle"}, 32'(s[10]), 32'd1);
        drv(wide, 1'b1, a, b, 1'b1);
        tick();
        drv(wide, 1'b0, ~a, ~b, 1'b0);
        lat = 0;
        s = st(wide);
        while (!s[9] && lat < 20) begin
            if (rnd_rdy) drv(wide, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            tick();
            drv(wide, 1'b0, ~a, ~b, 1'b0);
            lat++;
            s = st(wide);
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".diff"}, 32'(s[7:0]), 32'(exp_diff));
        check({tag, ".borrow"}, 32'(s[8]), 32'(exp_bor));
        if (chk_ovf) check({tag, ".ovf"}, 32'(s[11]), 32'(exp_ovf));
        s0 = s;
        for (int i = 0; i < hold; i++) begin
            drv(wide, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
            tick();
            s = st(wide);
            check({tag, ".hold_state"}, 32'(s), 32'(s0));
        end
        drv(wide, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        drv(wide, 1'b0, 8'h00, 8'h00, 1'b0);
        s = st(wide);
        check({tag, ".out_valid_drop"}, 32'(s[9]), 32'd0);
        check({tag, ".in_ready_back"}, 32'(s[10]), 32'd1);
        check({tag, ".diff_kept_idle"}, 32'(s[8:0]), 32'(s0[8:0]));
    endtask

    initial begin
        vec_t        vt [6];
        logic [11:0] s;
        logic [8:0]  ref9;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rovf;

        n_cmp  = 0;
        n_fail = 0;
        vt[0] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vt[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vt[2] = '{8'hAB, 8'hAB, 8'h00, 1'b0};
        vt[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vt[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vt[5] = '{8'h3C, 8'hC3, 8'h79, 1'b1};

        drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drv(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        resetn = 1'b0;
        tick();
        tick();
        check("reset.narrow", 32'(st(1'b0)), 32'h400);
        check("reset.wide", 32'(st(1'b1)), 32'h400);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_op(1'b0, vt[i].a, vt[i].b, vt[i].diff, vt[i].bor, 1'b0, 1'b0, 4, 0, 1'b0,
                   $sformatf("vec%0d", i));

        // Backpressure: result must sit still with in_valid pulses ignored.
        run_op(1'b0, 8'h55, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 4, 5, 1'b0, "backpressure");

        // Reset two cycles into BUSY.
        drv(1'b0, 1'b1, 8'h33, 8'h11, 1'b0);
        tick();
        drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check("midreset.outputs", 32'(st(1'b0)), 32'h400);
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            s = st(1'b0);
            check("midreset.no_spurious_valid", 32'(s[9]), 32'd0);
        end
        run_op(1'b0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 4, 0, 1'b0, "after_reset");

`ifdef CHUNKED_SUB_SIGNED_OVF_EN
        run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, "wide_ovf");
        run_op(1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0, "wide_noovf");
`else
        run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, "wide_a");
        run_op(1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, "wide_b");
`endif

        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            ref9 = {1'b0, ra} - {1'b0, rb};
            rovf = (ra[7] != rb[7]) && (ref9[7] != ra[7]);
`ifdef CHUNKED_SUB_SIGNED_OVF_EN
            run_op(1'b0, ra, rb, ref9[7:0], ref9[8], 1'b1, rovf, 4,
                   int'($urandom_range(0, 3)), 1'b1, "sweep");
`else
            run_op(1'b0, ra, rb, ref9[7:0], ref9[8], 1'b0, rovf, 4,
                   int'($urandom_range(0, 3)), 1'b1, "sweep");
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
